// File: rtl/apb_sched_pkg.sv
// Shared encodings and constants for the APB request scheduler.
package apb_sched_pkg;

  localparam int unsigned IDX_W  = 4;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_ACC  = 2'd2,
    S_RESP = 2'd3
  } sched_state_e;

  // APB master Out_State values
  localparam logic [1:0] M_IDLE   = 2'd0;
  localparam logic [1:0] M_SETUP  = 2'd1;
  localparam logic [1:0] M_ACCESS = 2'd2;

  // Granted transfer as presented to the APB master
  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } xfer_t;

endpackage

// File: rtl/apb_rdata_mux.sv
// Selects the addressed slave's read data and ready; zero for an index with no slave.
module apb_rdata_mux
  import apb_sched_pkg::*;
#(
  parameter int unsigned NUM_SLAVES = 1
) (
  input  logic [IDX_W-1:0]             idx,
  input  logic [NUM_SLAVES*DATA_W-1:0] prdata_vec,
  input  logic [NUM_SLAVES-1:0]        pready_vec,
  output logic [DATA_W-1:0]            rdata_c,
  output logic                         ready_c
);

  always_comb begin
    rdata_c = '0;
    ready_c = 1'b0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (idx == IDX_W'(i)) begin
        rdata_c = prdata_vec[i*DATA_W +: DATA_W];
        ready_c = pready_vec[i];
      end
    end
  end

endmodule

// File: rtl/apb_req_scheduler.sv
// Round-robin read/write scheduler in front of the APB master: grants one request
// at a time, drives the master request port, decodes the slave and returns completion.
module apb_req_scheduler
  import apb_sched_pkg::*;
#(
  parameter int unsigned NUM_SLAVES = 1,
  parameter int unsigned SLV_SHIFT  = 12
) (
  input  logic                         PCLK,
  input  logic                         PRESETn,
  input  logic                         wr_req,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [DATA_W-1:0]            wr_data,
  output logic                         wr_done,
  output logic                         wr_err,
  input  logic                         rd_req,
  input  logic [ADDR_W-1:0]            rd_addr,
  output logic                         rd_done,
  output logic                         rd_err,
  output logic [DATA_W-1:0]            rd_data,
  output logic                         STREQ,
  output logic                         SWRT,
  output logic                         SSEL,
  output logic [ADDR_W-1:0]            SADDR,
  output logic [DATA_W-1:0]            SWDATA,
  output logic [NUM_SLAVES-1:0]        psel_vec,
  input  logic [1:0]                   m_state,
  input  logic [NUM_SLAVES-1:0]        PREADY,
  input  logic [NUM_SLAVES*DATA_W-1:0] prdata_vec,
  input  logic                         PSLVERR
);

  localparam int unsigned CMP_W = IDX_W + 1;

  sched_state_e            state_q, state_d;
  xfer_t                   xfer_q, xfer_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [NUM_SLAVES-1:0]   psel_q, psel_d;
  logic                    last_wr_q, last_wr_d;
  logic                    streq_q, streq_d;
  logic                    ssel_q, ssel_d;
  logic                    wr_done_q, wr_done_d;
  logic                    rd_done_q, rd_done_d;
  logic                    wr_err_q, wr_err_d;
  logic                    rd_err_q, rd_err_d;
  logic [DATA_W-1:0]       rd_data_q, rd_data_d;

  logic                    gnt_wr;
  logic [ADDR_W-1:0]       gnt_addr;
  logic [IDX_W-1:0]        gnt_idx;
  logic [DATA_W-1:0]       mux_rdata_c;
  logic                    mux_ready_c;

  apb_rdata_mux #(
    .NUM_SLAVES (NUM_SLAVES)
  ) u_rdata_mux (
    .idx        (idx_q),
    .prdata_vec (prdata_vec),
    .pready_vec (PREADY),
    .rdata_c    (mux_rdata_c),
    .ready_c    (mux_ready_c)
  );

  // Round-robin pick: on a tie the side that did not win last time gets the grant
  always_comb begin
    gnt_wr   = wr_req && !(rd_req && last_wr_q);
    gnt_addr = gnt_wr ? wr_addr : rd_addr;
    gnt_idx  = gnt_addr[SLV_SHIFT +: IDX_W];
  end

  always_comb begin
    state_d   = state_q;
    xfer_d    = xfer_q;
    idx_d     = idx_q;
    psel_d    = psel_q;
    last_wr_d = last_wr_q;
    wr_done_d = 1'b0;
    rd_done_d = 1'b0;
    wr_err_d  = wr_err_q;
    rd_err_d  = rd_err_q;
    rd_data_d = rd_data_q;

    unique case (state_q)
      S_IDLE: begin
        if (wr_req || rd_req) begin
          last_wr_d    = gnt_wr;
          xfer_d.wr    = gnt_wr;
          xfer_d.addr  = gnt_addr;
          xfer_d.wdata = gnt_wr ? wr_data : DATA_W'(0);
          idx_d        = gnt_idx;
          if (CMP_W'(gnt_idx) < CMP_W'(NUM_SLAVES)) begin
            state_d = S_REQ;
            for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
              psel_d[i] = (gnt_idx == IDX_W'(i));
            end
          end else begin
            // Unmapped address: answered locally, the APB bus is never touched
            state_d = S_RESP;
            psel_d  = '0;
            if (gnt_wr) begin
              wr_done_d = 1'b1;
              wr_err_d  = 1'b1;
            end else begin
              rd_done_d = 1'b1;
              rd_err_d  = 1'b1;
              rd_data_d = '0;
            end
          end
        end
      end
      S_REQ: begin
        if (m_state == M_SETUP) state_d = S_ACC;
      end
      S_ACC: begin
        if ((m_state == M_ACCESS) && mux_ready_c) begin
          state_d = S_RESP;
          if (xfer_q.wr) begin
            wr_done_d = 1'b1;
            wr_err_d  = PSLVERR;
          end else begin
            rd_done_d = 1'b1;
            rd_err_d  = PSLVERR;
            rd_data_d = mux_rdata_c;
          end
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        psel_d  = '0;
      end
      default: state_d = S_IDLE;
    endcase

    streq_d = (state_d == S_REQ);
    ssel_d  = (state_d == S_REQ) || (state_d == S_ACC);
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q   <= S_IDLE;
      xfer_q    <= '0;
      idx_q     <= '0;
      psel_q    <= '0;
      last_wr_q <= 1'b0;
      streq_q   <= 1'b0;
      ssel_q    <= 1'b0;
      wr_done_q <= 1'b0;
      rd_done_q <= 1'b0;
      wr_err_q  <= 1'b0;
      rd_err_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      xfer_q    <= xfer_d;
      idx_q     <= idx_d;
      psel_q    <= psel_d;
      last_wr_q <= last_wr_d;
      streq_q   <= streq_d;
      ssel_q    <= ssel_d;
      wr_done_q <= wr_done_d;
      rd_done_q <= rd_done_d;
      wr_err_q  <= wr_err_d;
      rd_err_q  <= rd_err_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign STREQ    = streq_q;
  assign SSEL     = ssel_q;
  assign SWRT     = xfer_q.wr;
  assign SADDR    = xfer_q.addr;
  assign SWDATA   = xfer_q.wdata;
  assign psel_vec = psel_q;
  assign wr_done  = wr_done_q;
  assign wr_err   = wr_err_q;
  assign rd_done  = rd_done_q;
  assign rd_err   = rd_err_q;
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_apb_req_scheduler.sv
// Bench for apb_req_scheduler: APB master/slave stand-in, transaction-level timing
// model checked every cycle, plus directed transfers with literal expectations.
module tb_apb_req_scheduler;

  localparam int unsigned NS = 4;
  localparam logic [127:0] PRDATA = {32'h8765_4321, 32'h1234_5678, 32'hCAFE_0001, 32'h0BAD_F00D};

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        wr_req, rd_req;
  logic [31:0] wr_addr, wr_data, rd_addr;
  logic        wr_done, wr_err, rd_done, rd_err;
  logic [31:0] rd_data;
  logic        STREQ, SWRT, SSEL;
  logic [31:0] SADDR, SWDATA;
  logic [NS-1:0] psel_vec;
  logic [1:0]  m_state;
  logic [NS-1:0] PREADY;
  logic [127:0] prdata_vec;
  logic        PSLVERR;

  int   n_checks = 0;
  int   n_errs = 0;
  int   cyc = 0;
  int   wait_n = 0;
  int   acc_cnt = 0;
  logic pslverr_cfg = 1'b0;

  // Model state: one outstanding transfer described by its grant cycle and latency
  bit          check_en = 0;
  bit          act = 0;
  bit          granted_ever = 0;
  bit          last_wr = 0;
  int          next_arb = 0;
  int          t_c0 = 0;
  int          t_L = 0;
  int          t_idx = 0;
  bit          t_wr = 0;
  bit          t_dec = 0;
  bit          t_err = 0;
  logic [31:0] t_addr = '0;
  logic [31:0] t_wdata = '0;
  logic [31:0] t_rdata = '0;
  logic [31:0] e_rdata = '0;
  bit          e_rderr = 0;

  // Results of the last directed transfer
  int          r_lat, r_streq_at;
  logic        r_err, r_swrt;
  logic [31:0] r_rdat;
  logic [NS-1:0] r_psel;
  byte         order_q[$];

  apb_req_scheduler #(.NUM_SLAVES(NS), .SLV_SHIFT(12)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_done(wr_done), .wr_err(wr_err),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_done(rd_done), .rd_err(rd_err), .rd_data(rd_data),
    .STREQ(STREQ), .SWRT(SWRT), .SSEL(SSEL), .SADDR(SADDR), .SWDATA(SWDATA),
    .psel_vec(psel_vec), .m_state(m_state), .PREADY(PREADY), .prdata_vec(prdata_vec),
    .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  assign prdata_vec = PRDATA;
  assign PSLVERR    = pslverr_cfg;

  // APB master stand-in: Idle -> Setup on STREQ, Setup -> Access, Access -> Idle on ready
  always @(posedge PCLK) begin
    if (!PRESETn) begin
      m_state <= 2'd0;
      acc_cnt <= 0;
    end else begin
      case (m_state)
        2'd0: if (STREQ) m_state <= 2'd1;
        2'd1: begin m_state <= 2'd2; acc_cnt <= 0; end
        2'd2: if (|PREADY) m_state <= 2'd0; else acc_cnt <= acc_cnt + 1;
        default: m_state <= 2'd0;
      endcase
    end
  end

  always_comb begin
    PREADY = '0;
    if (m_state == 2'd2 && acc_cnt >= wait_n) PREADY[SADDR[13:12]] = 1'b1;
  end

  // Reference model: arbitration and expected latency computed per grant
  always @(posedge PCLK) begin
    if (!PRESETn) begin
      check_en     = 1;
      act          = 0;
      granted_ever = 0;
      last_wr      = 0;
      next_arb     = cyc + 1;
      e_rdata      = '0;
      e_rderr      = 0;
    end else begin
      if (cyc >= next_arb && (wr_req || rd_req)) begin
        t_wr    = wr_req && (!rd_req || !last_wr);
        last_wr = t_wr;
        t_addr  = t_wr ? wr_addr : rd_addr;
        t_wdata = t_wr ? wr_data : 32'h0;
        t_idx   = int'(t_addr[15:12]);
        t_dec   = (t_idx >= NS);
        t_L     = t_dec ? 1 : 4 + wait_n;
        t_err   = t_dec ? 1'b1 : pslverr_cfg;
        if (t_dec) t_rdata = 32'h0;
        else       t_rdata = PRDATA[32*t_idx +: 32];
        t_c0         = cyc;
        act          = 1;
        granted_ever = 1;
        next_arb     = cyc + t_L + 1;
      end
      if (act && (cyc + 1 == t_c0 + t_L) && !t_wr) begin
        e_rdata = t_rdata;
        e_rderr = t_err;
      end
    end
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    n_checks++;
    if (act_v !== exp_v) begin
      n_errs++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act_v, exp_v);
    end
  endtask

  task automatic cycle_check();
    int rel;
    bit in_tx, e_streq, e_ssel, e_wd, e_rd;
    logic [NS-1:0] e_psel;
    rel     = cyc - t_c0;
    in_tx   = act && rel >= 1 && rel <= t_L;
    e_streq = in_tx && !t_dec && rel <= 2;
    e_ssel  = in_tx && !t_dec && rel <= t_L - 1;
    e_wd    = in_tx && rel == t_L && t_wr;
    e_rd    = in_tx && rel == t_L && !t_wr;
    check("STREQ",   32'(STREQ),   32'(e_streq));
    check("SSEL",    32'(SSEL),    32'(e_ssel));
    check("wr_done", 32'(wr_done), 32'(e_wd));
    check("rd_done", 32'(rd_done), 32'(e_rd));
    check("rd_data", rd_data,      e_rdata);
    check("rd_err",  32'(rd_err),  32'(e_rderr));
    if (in_tx) begin
      e_psel = t_dec ? 4'b0000 : (4'(1) << t_idx);
      check("SWRT",     32'(SWRT),     32'(t_wr));
      check("SADDR",    SADDR,         t_addr);
      check("SWDATA",   SWDATA,        t_wdata);
      check("psel_vec", 32'(psel_vec), 32'(e_psel));
    end else if (!granted_ever) begin
      check("SWRT_rst",   32'(SWRT),     32'd0);
      check("SADDR_rst",  SADDR,         32'd0);
      check("SWDATA_rst", SWDATA,        32'd0);
      check("psel_rst",   32'(psel_vec), 32'd0);
      check("wr_err_rst", 32'(wr_err),   32'd0);
    end
    if (e_wd) check("wr_err", 32'(wr_err), 32'(t_err));
  endtask

  task automatic do_xfer(input bit is_wr, input logic [31:0] addr, input logic [31:0] data);
    int start;
    bit seen;
    @(negedge PCLK);
    if (is_wr) begin wr_req = 1; wr_addr = addr; wr_data = data; end
    else begin rd_req = 1; rd_addr = addr; end
    start = cyc; seen = 0; r_lat = 0; r_streq_at = 0;
    r_err = 1'bx; r_rdat = 'x; r_psel = 'x; r_swrt = 1'bx;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge PCLK);
      if (STREQ && r_streq_at == 0) begin
        r_streq_at = cyc - start;
        r_psel     = psel_vec;
        r_swrt     = SWRT;
      end
      if (is_wr ? wr_done : rd_done) begin
        seen   = 1;
        r_lat  = cyc - start;
        r_err  = is_wr ? wr_err : rd_err;
        r_rdat = rd_data;
      end
    end
    if (is_wr) wr_req = 0; else rd_req = 0;
    check("done_seen", 32'(seen), 32'd1);
  endtask

  // Keeps its request high across completions, presenting the next item at once
  task automatic run_side(input bit is_wr, input int n);
    int got;
    got = 0;
    @(negedge PCLK);
    if (is_wr) begin wr_req = 1; wr_addr = 32'h40; wr_data = 32'hA5A5_0000; end
    else begin rd_req = 1; rd_addr = 32'h1080; end
    for (int k = 0; k < 200 && got < n; k++) begin
      @(negedge PCLK);
      if (is_wr ? wr_done : rd_done) begin
        order_q.push_back(is_wr ? byte'("W") : byte'("R"));
        got++;
        if (got < n) begin
          if (is_wr) begin
            wr_addr = 32'((got % 4) * 4096 + 64);
            wr_data = 32'hA5A5_0000 + 32'(got);
          end else begin
            rd_addr = 32'(((got + 1) % 4) * 4096 + 128);
          end
        end else begin
          if (is_wr) wr_req = 0; else rd_req = 0;
        end
      end
    end
    check(is_wr ? "wr_side_count" : "rd_side_count", 32'(got), 32'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit   seen;
    byte  exp_b;
    PRESETn = 0; wr_req = 0; rd_req = 0;
    wr_addr = '0; wr_data = '0; rd_addr = '0;
    fork
      forever begin
        @(negedge PCLK);
        if (check_en) cycle_check();
      end
    join_none
    repeat (3) @(negedge PCLK);
    PRESETn = 1;
    check("rst_rd_data", rd_data, 32'h0);
    check("rst_STREQ", 32'(STREQ), 32'd0);

    // Single zero-wait write to slave 0
    do_xfer(1, 32'h0000_0004, 32'hDEAD_BEEF);
    check("wr_latency", 32'(r_lat), 32'd4);
    check("wr_err_val", 32'(r_err), 32'd0);
    check("wr_streq_cycle", 32'(r_streq_at), 32'd1);
    check("wr_psel", 32'(r_psel), 32'd1);
    check("wr_swrt", 32'(r_swrt), 32'd1);

    // Read from slave 2 with three wait states
    wait_n = 3;
    do_xfer(0, 32'h0000_2010, 32'h0);
    check("rd_latency", 32'(r_lat), 32'd7);
    check("rd_data_val", r_rdat, 32'h1234_5678);
    check("rd_err_val", 32'(r_err), 32'd0);
    check("rd_psel", 32'(r_psel), 32'h4);
    wait_n = 0;

    // Both sides requesting continuously
    fork
      run_side(1, 3);
      run_side(0, 3);
    join
    check("order_len", 32'(order_q.size()), 32'd6);
    for (int i = 0; i < 6 && i < order_q.size(); i++) begin
      exp_b = (i % 2 == 0) ? byte'("W") : byte'("R");
      check("grant_order", 32'(order_q[i]), 32'(exp_b));
    end

    // Unmapped read and write addresses
    do_xfer(0, 32'h0000_5000, 32'h0);
    check("dec_rd_latency", 32'(r_lat), 32'd1);
    check("dec_rd_err", 32'(r_err), 32'd1);
    check("dec_rd_data", r_rdat, 32'h0);
    check("dec_rd_streq", 32'(r_streq_at), 32'd0);
    do_xfer(1, 32'h0000_F000, 32'h1111_2222);
    check("dec_wr_latency", 32'(r_lat), 32'd1);
    check("dec_wr_err", 32'(r_err), 32'd1);

    // Slave error on a write, then a clean read
    pslverr_cfg = 1;
    do_xfer(1, 32'h0000_3008, 32'h0000_55AA);
    check("slverr_wr_latency", 32'(r_lat), 32'd4);
    check("slverr_wr_err", 32'(r_err), 32'd1);
    pslverr_cfg = 0;
    do_xfer(0, 32'h0000_1000, 32'h0);
    check("after_err_latency", 32'(r_lat), 32'd4);
    check("after_err_rd_err", 32'(r_err), 32'd0);
    check("after_err_rd_data", r_rdat, 32'hCAFE_0001);

    // Reset while the master is in Access
    wait_n = 5;
    @(negedge PCLK);
    rd_req = 1; rd_addr = 32'h0000_1000;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge PCLK);
      if (m_state == 2'd2) seen = 1;
    end
    check("acc_reached", 32'(seen), 32'd1);
    PRESETn = 0;
    @(negedge PCLK);
    PRESETn = 1; rd_req = 0;
    check("mid_rst_STREQ", 32'(STREQ), 32'd0);
    check("mid_rst_SSEL", 32'(SSEL), 32'd0);
    check("mid_rst_psel", 32'(psel_vec), 32'd0);
    check("mid_rst_SADDR", SADDR, 32'd0);
    check("mid_rst_rd_data", rd_data, 32'd0);
    wait_n = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge PCLK);
      check("mid_rst_no_done", 32'(rd_done), 32'd0);
    end
    do_xfer(1, 32'h0000_0010, 32'h0102_0304);
    check("post_rst_latency", 32'(r_lat), 32'd4);
    check("post_rst_err", 32'(r_err), 32'd0);

    repeat (5) @(negedge PCLK);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/apb_req_scheduler.md
# apb_req_scheduler

Sequencer and arbiter in front of the APB master. It accepts independent read and write requests from the AXI4-Lite front end and grants them round-robin, one at a time. For each granted transfer it drives the master's request port (STREQ/SWRT/SSEL/SADDR/SWDATA) and decodes the target slave. It tracks the master's Out_State and PREADY to detect completion and returns read data or error to the winning requester. Addresses that decode to no slave are answered locally, without an APB transfer.

## Interface
- NUM_SLAVES, 1, number of APB slaves (1..16); also sets the PREADY and PRDATA vector widths.
- SLV_SHIFT, 12, address bit where the slave index field starts; each slave owns a 2^SLV_SHIFT-byte window.
- PCLK  in  1  clock.
- PRESETn  in  1  reset; synchronous, active-low. One clock; the reset is synchronous and active-low.
- wr_req / wr_addr / wr_data  in  1/32/32  write request; held stable until wr_done.
- wr_done / wr_err  out  1/1  one-cycle completion pulse, with error flag valid in the same cycle.
- rd_req / rd_addr  in  1/32  read request; held stable until rd_done.
- rd_done / rd_err / rd_data  out  1/1/32  one-cycle completion pulse, error flag, and read data (data valid with rd_done).
- STREQ / SWRT / SSEL  out  1/1/1  transfer request, direction and select to the APB master.
- SADDR / SWDATA  out  32/32  address and write data to the APB master.
- psel_vec  out  NUM_SLAVES  one-hot slave select; valid whenever SSEL=1.
- m_state  in  2  master Out_State: 0 Idle, 1 Setup, 2 Access.
- PREADY  in  NUM_SLAVES  per-slave ready.
- prdata_vec  in  32*NUM_SLAVES  flattened slave read data; slave i occupies bits [32i+31:32i].
- PSLVERR  in  1  slave error.

## Operation
- States:
  - S_IDLE: arbitrate.
  - S_REQ: STREQ=1; wait for m_state==1.
  - S_ACC: STREQ=0; wait for m_state==2 and PREADY[idx].
  - S_RESP: pulse done; go to S_IDLE.
- Arbitration happens in S_IDLE only, among requests high in that cycle.
  - Exactly one request high: grant it.
  - Both high: grant the side opposite last_grant.
  - last_grant resets to "read", so write wins the first tie.
  - last_grant updates on every grant.
- On grant, register the following, all held until S_RESP exits:
  - SADDR = addr; SWDATA = wr_data, or 0 for a read.
  - SWRT = 1 for a write.
  - idx = addr[SLV_SHIFT +: 4].
- Decode:
  - If idx < NUM_SLAVES, go to S_REQ and set psel_vec = 1<<idx.
  - Otherwise it is a decode error: go straight to S_RESP with err=1 and rd_data=0. STREQ/SSEL stay 0; the APB bus is untouched.
- SSEL = 1 in S_REQ and S_ACC only.
- Completion, in S_ACC when m_state==2 and PREADY[idx]=1:
  - Capture rd_data = prdata_vec[idx] (reads only; writes leave it unchanged).
  - Capture err = PSLVERR.
- S_RESP pulses wr_done or rd_done for exactly one cycle. rd_data and rd_err hold until the next rd_done.
- STREQ is low in S_ACC, so the master returns to Idle after every transfer. There are no back-to-back Setup cycles.
- A request that drops before it is granted is ignored. Dropping a request after grant is illegal; the transfer still completes.

## Timing
- Reset (synchronous, PRESETn=0 at an edge) applies the following, overriding any in-flight state (the master shares PRESETn):
  - State goes to S_IDLE.
  - STREQ, SWRT, SSEL, SADDR, SWDATA, psel_vec, all done/err outputs and rd_data go to 0.
  - last_grant goes to read.
- Zero-wait transfer, with the request sampled in cycle 0:
  - Cycle 1: S_REQ, STREQ=1.
  - Cycle 2: m_state=1.
  - Cycle 3: S_ACC, m_state=2, PREADY=1.
  - Cycle 4: done. Latency is 4 cycles.
- Each wait state adds 1 cycle.
- Decode error: done in cycle 1.
- The requester clears req at the edge that samples done. A request seen high in the S_IDLE cycle after S_RESP is a new request.
- If the master is not in Idle when S_REQ is entered (m_state≠0,1), STREQ stays high until m_state==1 is observed.

## Structure
- Shared package apb_sched_pkg holds:
  - scheduler state encodings;
  - master state constants (M_IDLE=0, M_SETUP=1, M_ACCESS=2);
  - the width constant IDX_W=4.
- One sub-module, apb_rdata_mux: a combinational selector of prdata_vec and PREADY by idx.
- Everything else is flat: FSM, arbiter and decode in one module. This fits in roughly 200 lines.

## Test plan
- Single write: wr_addr=0x0000_0004, wr_data=0xDEAD_BEEF, zero-wait slave. Expect STREQ high in cycle 1, SWRT=1, psel_vec=1, wr_done in cycle 4, wr_err=0.
- Read from slave 2 (NUM_SLAVES=4, SLV_SHIFT=12): rd_addr=0x2010, prdata slice 2 = 0x1234_5678, PREADY[2] low for 3 cycles. Expect rd_done in cycle 7 with rd_data=0x1234_5678.
- Both requests high continuously: grants alternate W, R, W, R, and never two transfers overlap.
- Decode error: rd_addr=0x5000 with NUM_SLAVES=4. Expect rd_done in cycle 1, rd_err=1, rd_data=0, STREQ/SSEL never high.
- PSLVERR=1 at completion of a write. Expect wr_err=1 with wr_done; the next transfer proceeds normally.
- PRESETn low during S_ACC. Expect all outputs 0 at the next edge, no done pulse, and a fresh request after reset to complete normally.
